mips_shift_unit_arbiter: RTL and testbench

Sequential front-end that shares the single combinational 32-bit MIPS shift unit (SLL/SRL/SRA/ROTR) between two requesters, A (execute-stage datapath) and B (auxiliary/coprocessor path). It arbitrates round-robin, drives the shifter's data/amount/type inputs from the granted request, and registers the result into a response slot. Each requester gets its result back through a valid/ready handshake.

---
 rtl/mips_shift_unit_arbiter.sv | 140 ++++++++++++++
 tb/tb_mips_shift_unit_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_shift_unit_arbiter.sv
// Purpose: round-robin front-end sharing one 32-bit MIPS shifter (SLL/SRL/SRA/ROTR) between requesters A and B.
// Latency: a request accepted at edge N shows resp_valid and its result in cycle N+1; one result per cycle sustained.
// Backpressure: while the owner holds resp_ready low, both req_ready stay low and the held result is frozen.
module mips_shift_unit_arbiter #(
   parameter bit FIRST_GRANT = 1'b0
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        A_req_valid,
   output logic        A_req_ready,
   input  logic [31:0] A_data_in,
   input  logic [4:0]  A_amount,
   input  logic [1:0]  A_type,
   output logic        A_resp_valid,
   input  logic        A_resp_ready,
   output logic [31:0] A_result,
   input  logic        B_req_valid,
   output logic        B_req_ready,
   input  logic [31:0] B_data_in,
   input  logic [4:0]  B_amount,
   input  logic [1:0]  B_type,
   output logic        B_resp_valid,
   input  logic        B_resp_ready,
   output logic [31:0] B_result,
   output logic        Busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   localparam logic [1:0] SH_SLL  = 2'd0;
   localparam logic [1:0] SH_SRL  = 2'd1;
   localparam logic [1:0] SH_SRA  = 2'd2;
   localparam logic [1:0] SH_ROTR = 2'd3;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;   // 0 = A, 1 = B
   logic        last_q, last_d;     // requester granted most recently
   logic [31:0] a_res_q, a_res_d;
   logic [31:0] b_res_q, b_res_d;

   logic        any_vld;
   logic        gnt;
   logic        hs;
   logic        free;
   logic        accept;
   logic [31:0] sh_dat;
   logic [4:0]  sh_amt;
   logic [1:0]  sh_typ;
   logic [31:0] sh_res;
   logic [63:0] rot_dbl;

   // Response valids depend only on registered state, so req_valid never reaches resp_valid.
   assign A_resp_valid = (state_q == RESP) && !owner_q;
   assign B_resp_valid = (state_q == RESP) &&  owner_q;

   // Owner handshake frees the slot in the same cycle so back-to-back results are possible.
   assign hs   = owner_q ? (B_resp_valid && B_resp_ready) : (A_resp_valid && A_resp_ready);
   assign free = (state_q == IDLE) || hs;

   // Round-robin grant: a lone requester wins, contention goes to the one not served last.
   always_comb begin
      any_vld = A_req_valid || B_req_valid;
      if (A_req_valid && !B_req_valid) begin
         gnt = 1'b0;
      end else if (B_req_valid && !A_req_valid) begin
         gnt = 1'b1;
      end else begin
         gnt = ~last_q;
      end
   end

   assign accept = free && any_vld;

   // Steer the granted operands into the shared shifter and evaluate it.
   always_comb begin
      sh_dat  = gnt ? B_data_in : A_data_in;
      sh_amt  = gnt ? B_amount  : A_amount;
      sh_typ  = gnt ? B_type    : A_type;
      // Rotating a doubled word keeps amount 0 as a pass-through without special casing.
      rot_dbl = {sh_dat, sh_dat} >> sh_amt;
      case (sh_typ)
         SH_SLL:  sh_res = sh_dat << sh_amt;
         SH_SRL:  sh_res = sh_dat >> sh_amt;
         SH_SRA:  sh_res = $unsigned($signed(sh_dat) >>> sh_amt);
         SH_ROTR: sh_res = rot_dbl[31:0];
         default: sh_res = sh_dat;
      endcase
   end

   // State register: reset discards any held result and arms FIRST_GRANT for the first contention.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= ~FIRST_GRANT;
         a_res_q <= '0;
         b_res_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         a_res_q <= a_res_d;
         b_res_q <= b_res_d;
      end
   end

   // Next state: an accept always (re)fills the slot; a bare handshake empties it.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      a_res_d = a_res_q;
      b_res_d = b_res_q;
      if (accept) begin
         state_d = RESP;
         owner_d = gnt;
         last_d  = gnt;
         if (gnt) begin
            b_res_d = sh_res;
         end else begin
            a_res_d = sh_res;
         end
      end else if (hs) begin
         state_d = IDLE;
      end
   end

   // Outputs: only the granted, valid requester sees ready; results come straight from registers.
   always_comb begin
      A_req_ready = free && A_req_valid && !gnt;
      B_req_ready = free && B_req_valid &&  gnt;
      A_result    = a_res_q;
      B_result    = b_res_q;
      Busy        = (state_q == RESP);
   end

endmodule

// File: tb/tb_mips_shift_unit_arbiter.sv
// Purpose: self-checking bench for mips_shift_unit_arbiter (directed scenarios plus random traffic).
// Latency: compares every cycle on the falling edge against a bit-level behavioural model.
// Backpressure: random resp_ready stalls; requesters keep operands stable while waiting.
module tb_mips_shift_unit_arbiter;

   logic        Clk, Rst;
   logic        A_req_valid, A_req_ready, A_resp_valid, A_resp_ready;
   logic [31:0] A_data_in, A_result;
   logic [4:0]  A_amount;
   logic [1:0]  A_type;
   logic        B_req_valid, B_req_ready, B_resp_valid, B_resp_ready;
   logic [31:0] B_data_in, B_result;
   logic [4:0]  B_amount;
   logic [1:0]  B_type;
   logic        Busy;

   int tests = 0;
   int fails = 0;

   mips_shift_unit_arbiter #(.FIRST_GRANT(1'b0)) dut (
      .Clk(Clk), .Rst(Rst),
      .A_req_valid(A_req_valid), .A_req_ready(A_req_ready), .A_data_in(A_data_in),
      .A_amount(A_amount), .A_type(A_type), .A_resp_valid(A_resp_valid),
      .A_resp_ready(A_resp_ready), .A_result(A_result),
      .B_req_valid(B_req_valid), .B_req_ready(B_req_ready), .B_data_in(B_data_in),
      .B_amount(B_amount), .B_type(B_type), .B_resp_valid(B_resp_valid),
      .B_resp_ready(B_resp_ready), .B_result(B_result),
      .Busy(Busy)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Shift defined bit by bit from the instruction semantics.
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt, input int t);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         case (t)
            0: r[i] = (i >= amt) ? d[i - amt] : 1'b0;
            1: r[i] = (i + amt <= 31) ? d[i + amt] : 1'b0;
            2: r[i] = (i + amt <= 31) ? d[i + amt] : d[31];
            default: r[i] = d[(i + amt) % 32];
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one response slot, who owns it, who was served last.
   logic        m_busy, m_owner, m_last;
   logic [31:0] m_ares, m_bres;
   logic        e_gnt, e_hs, e_free, e_ar, e_br;

   always_comb begin
      if (A_req_valid && !B_req_valid)      e_gnt = 1'b0;
      else if (B_req_valid && !A_req_valid) e_gnt = 1'b1;
      else                                  e_gnt = ~m_last;
      e_hs   = m_busy && (m_owner ? B_resp_ready : A_resp_ready);
      e_free = !m_busy || e_hs;
      e_ar   = e_free && A_req_valid && !e_gnt;
      e_br   = e_free && B_req_valid &&  e_gnt;
   end

   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         m_busy  <= 1'b0;
         m_owner <= 1'b0;
         m_last  <= 1'b1;
         m_ares  <= '0;
         m_bres  <= '0;
      end else if (e_ar) begin
         m_busy  <= 1'b1;
         m_owner <= 1'b0;
         m_last  <= 1'b0;
         m_ares  <= ref_shift(A_data_in, int'(A_amount), int'(A_type));
      end else if (e_br) begin
         m_busy  <= 1'b1;
         m_owner <= 1'b1;
         m_last  <= 1'b1;
         m_bres  <= ref_shift(B_data_in, int'(B_amount), int'(B_type));
      end else if (e_hs) begin
         m_busy  <= 1'b0;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge Clk) begin
      if (!Rst) begin
         chk("a_req_ready",  {31'b0, A_req_ready},  {31'b0, e_ar});
         chk("b_req_ready",  {31'b0, B_req_ready},  {31'b0, e_br});
         chk("a_resp_valid", {31'b0, A_resp_valid}, {31'b0, m_busy && !m_owner});
         chk("b_resp_valid", {31'b0, B_resp_valid}, {31'b0, m_busy && m_owner});
         chk("busy",         {31'b0, Busy},         {31'b0, m_busy});
         chk("a_result",     A_result, m_ares);
         chk("b_result",     B_result, m_bres);
      end
   end

   // Remember whether each request was taken at the coming edge.
   logic a_acc, b_acc;
   always @(negedge Clk) begin
      a_acc <= A_req_valid && A_req_ready;
      b_acc <= B_req_valid && B_req_ready;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge Clk);
   endtask

   task automatic idle();
      A_req_valid = 1'b0; B_req_valid = 1'b0;
      A_resp_ready = 1'b1; B_resp_ready = 1'b1;
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      idle();
      tick();
      tick();
      Rst = 1'b0;
   endtask

   task automatic rand_drive();
      if (!A_req_valid || a_acc) begin
         A_req_valid = 1'($urandom_range(0, 1));
         A_data_in   = $urandom;
         A_amount    = 5'($urandom_range(0, 31));
         A_type      = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 7) == 0) begin
         A_req_valid = 1'b0;
      end
      if (!B_req_valid || b_acc) begin
         B_req_valid = 1'($urandom_range(0, 1));
         B_data_in   = $urandom;
         B_amount    = 5'($urandom_range(0, 31));
         B_type      = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 7) == 0) begin
         B_req_valid = 1'b0;
      end
      A_resp_ready = ($urandom_range(0, 3) != 0);
      B_resp_ready = ($urandom_range(0, 3) != 0);
   endtask

   logic [31:0] bd_d [6];
   logic [4:0]  bd_a [6];
   logic [1:0]  bd_t [6];
   logic [31:0] bd_e [6];
   logic [31:0] held;

   initial begin
      Rst = 1'b1;
      idle();
      A_data_in = '0; A_amount = '0; A_type = '0;
      B_data_in = '0; B_amount = '0; B_type = '0;
      #1;
      chk("rst_busy",     {31'b0, Busy},         32'd0);
      chk("rst_a_result", A_result,               32'd0);
      chk("rst_a_valid",  {31'b0, A_resp_valid}, 32'd0);
      do_reset();

      // Pin the model with hand-computed values.
      chk("mdl_sll",  ref_shift(32'h00000001, 4, 0),  32'h00000010);
      chk("mdl_sra",  ref_shift(32'h80000000, 31, 2), 32'hFFFFFFFF);
      chk("mdl_rotr", ref_shift(32'h00000003, 1, 3),  32'h80000001);

      // Single requester.
      A_req_valid = 1'b1; A_data_in = 32'h1; A_amount = 5'd4; A_type = 2'd0;
      A_resp_ready = 1'b0;
      at_neg();
      chk("single_rdy", {31'b0, A_req_ready}, 32'd1);
      tick();
      A_req_valid = 1'b0;
      at_neg();
      chk("single_vld", {31'b0, A_resp_valid}, 32'd1);
      chk("single_res", A_result, 32'h00000010);
      chk("single_bvld", {31'b0, B_resp_valid}, 32'd0);
      A_resp_ready = 1'b1;
      tick();

      // Contention right after reset: A first, B next cycle.
      do_reset();
      A_req_valid = 1'b1; A_data_in = 32'h80000000; A_amount = 5'd31; A_type = 2'd2;
      B_req_valid = 1'b1; B_data_in = 32'h00000001; B_amount = 5'd1;  B_type = 2'd3;
      at_neg();
      chk("cont_a_first", {30'b0, A_req_ready, B_req_ready}, 32'd2);
      tick();
      A_req_valid = 1'b0;
      at_neg();
      chk("cont_a_res", A_result, 32'hFFFFFFFF);
      chk("cont_b_rdy", {31'b0, B_req_ready}, 32'd1);
      tick();
      B_req_valid = 1'b0;
      at_neg();
      chk("cont_b_vld", {31'b0, B_resp_valid}, 32'd1);
      chk("cont_b_res", B_result, 32'h80000000);
      tick();

      // Fairness: continuous contention alternates A, B, A, B.
      do_reset();
      A_req_valid = 1'b1; B_req_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         at_neg();
         chk("fair_a", {31'b0, A_req_ready}, {31'b0, (i % 2 == 0)});
         chk("fair_b", {31'b0, B_req_ready}, {31'b0, (i % 2 == 1)});
         if (i > 0) chk("fair_busy", {31'b0, Busy}, 32'd1);
         tick();
      end
      idle();
      tick();

      // Backpressure: A result held while B waits.
      A_req_valid = 1'b1; A_data_in = 32'hDEADBEEF; A_amount = 5'd8; A_type = 2'd1;
      A_resp_ready = 1'b0;
      tick();
      A_req_valid = 1'b0;
      B_req_valid = 1'b1; B_data_in = 32'h0000F00F; B_amount = 5'd4; B_type = 2'd0;
      held = 32'h00DEADBE;
      for (int i = 0; i < 5; i++) begin
         at_neg();
         chk("bp_b_rdy", {31'b0, B_req_ready}, 32'd0);
         chk("bp_a_res", A_result, held);
         tick();
      end
      A_resp_ready = 1'b1;
      at_neg();
      chk("bp_hs_b_rdy", {31'b0, B_req_ready}, 32'd1);
      tick();
      B_req_valid = 1'b0;
      at_neg();
      chk("bp_b_vld", {31'b0, B_resp_valid}, 32'd1);
      chk("bp_b_res", B_result, 32'h000F00F0);
      tick();

      // Boundary operations through requester A.
      bd_d = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'hF0000000, 32'h00000003};
      bd_a = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd1};
      bd_t = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3};
      bd_e = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h0F000000, 32'h80000001};
      for (int i = 0; i < 6; i++) begin
         A_req_valid = 1'b1; A_data_in = bd_d[i]; A_amount = bd_a[i]; A_type = bd_t[i];
         tick();
         A_req_valid = 1'b0;
         at_neg();
         chk("boundary", A_result, bd_e[i]);
         tick();
      end

      // Reset in the middle of a pending A response.
      A_req_valid = 1'b1; A_data_in = 32'h0000000F; A_amount = 5'd2; A_type = 2'd0;
      A_resp_ready = 1'b0;
      tick();
      A_req_valid = 1'b0;
      at_neg();
      chk("pre_rst_vld", {31'b0, A_resp_valid}, 32'd1);
      #2;
      Rst = 1'b1;
      #1;
      chk("mid_rst_vld",  {31'b0, A_resp_valid}, 32'd0);
      chk("mid_rst_busy", {31'b0, Busy},         32'd0);
      chk("mid_rst_ares", A_result,               32'd0);
      chk("mid_rst_bres", B_result,               32'd0);
      tick();
      Rst = 1'b0;
      A_req_valid = 1'b1;
      at_neg();
      chk("post_rst_rdy", {31'b0, A_req_ready}, 32'd1);
      tick();
      idle();
      tick();

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rand_drive();
         tick();
      end
      idle();
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
